// File: rtl/pwr_wr_arbiter.sv
// Two-channel AXI-Lite write arbiter: maestro (register index) and fsm (byte address) requesters.
// Optional write-error capture enabled by defining PWR_WR_ERR_CHECK_EN.
module pwr_wr_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter logic [31:0] MAESTRO_BASE = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [31:0]         maestro_adress_i,
    input  logic [31:0]         maestro_data_i,
    input  logic                maestro_req_i,
    output logic                maestro_valid_o,
    output logic                maestro_ack_o,

    input  logic [31:0]         fsm_adress_i,
    input  logic [31:0]         fsm_data_i,
    input  logic                fsm_req_i,
    output logic                fsm_valid_o,
    output logic                fsm_ack_o,

    output logic [ADDR_W-1:0]   aw_addr,
    output logic [2:0]          aw_prot,
    output logic                aw_valid,
    input  logic                aw_ready,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] w_strb,
    output logic                w_valid,
    input  logic                w_ready,
    input  logic [1:0]          b_resp,
    input  logic                b_valid,
    output logic                b_ready,

    output logic                err_o,
    output logic                err_src_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q;
    logic                m_req_q, f_req_q;
    logic                m_arm_q, f_arm_q;
    logic                m_pend_q, f_pend_q;
    logic [31:0]         m_addr_q, m_data_q, f_addr_q, f_data_q;
    logic                grant_q;
    logic                aw_valid_q, w_valid_q, b_ready_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic                m_ack_q, f_ack_q;

    logic                m_edge, f_edge;
    logic [31:0]         m_byte_addr;

    // Arm bits block an edge until req_i has been seen low once after reset.
    assign m_edge      = maestro_req_i & ~m_req_q & m_arm_q;
    assign f_edge      = fsm_req_i & ~f_req_q & f_arm_q;
    assign m_byte_addr = MAESTRO_BASE + (m_addr_q << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            m_req_q    <= 1'b0;
            f_req_q    <= 1'b0;
            m_arm_q    <= 1'b0;
            f_arm_q    <= 1'b0;
            m_pend_q   <= 1'b0;
            f_pend_q   <= 1'b0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            f_addr_q   <= '0;
            f_data_q   <= '0;
            grant_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            m_ack_q    <= 1'b0;
            f_ack_q    <= 1'b0;
        end else begin
            m_req_q <= maestro_req_i;
            f_req_q <= fsm_req_i;
            m_arm_q <= m_arm_q | ~maestro_req_i;
            f_arm_q <= f_arm_q | ~fsm_req_i;
            m_ack_q <= 1'b0;
            f_ack_q <= 1'b0;

            if (m_edge && !m_pend_q) begin
                m_pend_q <= 1'b1;
                m_addr_q <= maestro_adress_i;
                m_data_q <= maestro_data_i;
            end
            if (f_edge && !f_pend_q) begin
                f_pend_q <= 1'b1;
                f_addr_q <= fsm_adress_i;
                f_data_q <= fsm_data_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (m_pend_q) begin
                        grant_q    <= 1'b0;
                        aw_addr_q  <= ADDR_W'(m_byte_addr);
                        w_data_q   <= DATA_W'(m_data_q);
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= StIssue;
                    end else if (f_pend_q) begin
                        grant_q    <= 1'b1;
                        aw_addr_q  <= ADDR_W'(f_addr_q);
                        w_data_q   <= DATA_W'(f_data_q);
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (aw_ready) aw_valid_q <= 1'b0;
                    if (w_ready)  w_valid_q  <= 1'b0;
                    if ((!aw_valid_q || aw_ready) && (!w_valid_q || w_ready)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (b_valid) begin
                        b_ready_q <= 1'b0;
                        state_q   <= StIdle;
                        if (grant_q) begin
                            f_pend_q <= 1'b0;
                            f_ack_q  <= 1'b1;
                        end else begin
                            m_pend_q <= 1'b0;
                            m_ack_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef PWR_WR_ERR_CHECK_EN
    logic err_q, err_src_q;
    logic b_hs;

    assign b_hs = b_valid & b_ready_q & (state_q == StResp);

    // Sticky: only the first failing response is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_src_q <= 1'b0;
        end else if (b_hs && (b_resp != 2'b00) && !err_q) begin
            err_q     <= 1'b1;
            err_src_q <= grant_q;
        end
    end

    assign err_o     = err_q;
    assign err_src_o = err_src_q;
`else
    logic unused_b_resp;
    assign unused_b_resp = ^b_resp;
    assign err_o         = 1'b0;
    assign err_src_o     = 1'b0;
`endif

    assign maestro_valid_o = m_pend_q | m_ack_q;
    assign fsm_valid_o     = f_pend_q | f_ack_q;
    assign maestro_ack_o   = m_ack_q;
    assign fsm_ack_o       = f_ack_q;
    assign aw_addr         = aw_addr_q;
    assign aw_prot         = 3'b000;
    assign aw_valid        = aw_valid_q;
    assign w_data          = w_data_q;
    assign w_strb          = '1;
    assign w_valid         = w_valid_q;
    assign b_ready         = b_ready_q;

endmodule

// File: doc/pwr_wr_arbiter.md
PWR_WR_ARBITER -- requirements
Module: pwr_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter MAESTRO_BASE, default 32'h0000_3000, base byte address of the maestro register window.
REQ-004 SHALL have ports: clk in 1, sole clock; rst in 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: maestro_adress_i in 32, register index; maestro_data_i in 32; maestro_req_i in 1; maestro_valid_o out 1, maestro request pending or in flight; maestro_ack_o out 1, one-cycle completion pulse.
REQ-006 SHALL have ports: fsm_adress_i in 32, byte address; fsm_data_i in 32; fsm_req_i in 1; fsm_valid_o out 1; fsm_ack_o out 1. Meanings match the maestro ports.
REQ-007 SHALL have AXI-Lite write-master ports: aw_addr out ADDR_W; aw_prot out 3; aw_valid out 1; aw_ready in 1; w_data out DATA_W; w_strb out DATA_W/8; w_valid out 1; w_ready in 1; b_resp in 2; b_valid in 1; b_ready out 1.
REQ-008 SHALL have ports: err_o out 1, sticky write-error flag; err_src_o out 1, 0 = maestro, 1 = fsm.

Function
REQ-009 SHALL capture a request on the rising edge of req_i (req_i high, previous-cycle req_i low), latching the address and data into that channel's single-entry pending buffer.
REQ-010 SHALL ignore a rising edge on a channel whose buffer is already pending or in flight, leaving the buffer unchanged.
REQ-011 SHALL drive valid_o high from the cycle after capture through the cycle of its ack_o pulse.
REQ-012 SHALL use FSM states IDLE -> ISSUE -> RESP -> IDLE, and only IDLE arbitrates.
REQ-013 SHALL, in IDLE, grant maestro first if both channels are pending, else whichever channel is pending, then move to ISSUE.
REQ-014 SHALL spend at least one cycle in IDLE between transactions.
REQ-015 SHALL, in ISSUE, hold aw_valid and w_valid high with stable payload; each valid SHALL drop after its own handshake; the FSM SHALL go to RESP once both handshakes are done, in any order or in the same cycle.
REQ-016 SHALL set the maestro aw_addr to MAESTRO_BASE + (maestro_adress_i << 2), truncated to ADDR_W bits.
REQ-017 SHALL pass the fsm aw_addr through unchanged.
REQ-018 SHALL drive w_strb all ones and aw_prot 3'b000.
REQ-019 SHALL, in RESP, hold b_ready high; on b_valid it SHALL clear the granted buffer, pulse that channel's ack_o in the next cycle, and return to IDLE.
REQ-020 SHALL have a minimum latency of 4 cycles: req edge in cycle 0; aw/w valid in cycle 2; zero-wait-state ready in cycle 2 and b_valid in cycle 3; ack_o in cycle 4.
REQ-021 SHALL, when a new edge arrives on a channel in the same cycle its b handshake completes, ignore the new edge.
REQ-022 SHALL never assert both ack_o outputs in the same cycle.

Reset
REQ-023 SHALL, while rst is high, drive all outputs to 0 (aw_valid, w_valid, b_ready, valid_o, ack_o, err_o, err_src_o, aw_addr, w_data), clear both buffers and the edge detectors, and force IDLE.
REQ-024 SHALL, on rst in mid-transaction, abandon the transaction; no ack_o is issued for it.
REQ-025 SHALL require at least one low cycle on req_i after reset release before a rising edge is registered.

Configuration
REQ-026 SHALL, with PWR_WR_ERR_CHECK_EN defined, set err_o sticky and err_src_o to the granted channel on any b_resp != 2'b00; only the first error is recorded, and ack_o is still pulsed.
REQ-027 SHALL, without PWR_WR_ERR_CHECK_EN, tie err_o and err_src_o to 0 and ignore b_resp.

Verification
REQ-028 Single maestro: idx=2, data=1, zero-wait slave -> aw_addr=32'h3008, w_data=1, maestro_ack_o in cycle 4, one AXI write only.
REQ-029 Simultaneous edges: maestro (idx 0, data 2) and fsm (32'h100, 32'hAB) in the same cycle -> maestro write completes first, one IDLE cycle follows, then the fsm write to 32'h100; acks are in distinct cycles.
REQ-030 Split handshake: w_ready 3 cycles before aw_ready -> w_valid drops after its handshake, aw_valid stays high until aw_ready, a single b phase follows, then ack.
REQ-031 Back-to-back maestro: req dropped for one cycle after each ack, three requests -> three writes in order; an fsm request arriving mid-sequence is served before the next maestro write.
REQ-032 Error plus reset: with PWR_WR_ERR_CHECK_EN, fsm write gets b_resp=2'b10 -> err_o=1, err_src_o=1, ack still pulses; rst asserted during a later ISSUE -> all outputs 0 next cycle and no ack.
